// File: rtl/sysid_arb_pkg.sv
// Shared types and constants for the sysid access arbiter: FSM states, master
// indices and the two slave word addresses.
package sysid_arb_pkg;

    typedef enum logic [2:0] {
        BOOT_ID,
        BOOT_TS,
        CHECK,
        IDLE,
        SERVE
    } state_e;

    localparam logic MASTER_M0     = 1'b0;
    localparam logic MASTER_M1     = 1'b1;

    localparam logic SYSID_WORD_ID = 1'b0;
    localparam logic SYSID_WORD_TS = 1'b1;

endpackage

// File: rtl/sysid_rr_arbiter.sv
// Two-way round-robin pick: a lone requester wins outright, and a tie goes to the
// master that was not granted last.
module sysid_rr_arbiter
    import sysid_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        grant_valid = |req;
        grant_idx   = MASTER_M0;
        if (req == 2'b10 || (req == 2'b11 && last_grant == MASTER_M0)) begin
            grant_idx = MASTER_M1;
        end
    end

endmodule

// File: rtl/sysid_access_arbiter.sv
// Shares one combinational sysid slave (word 0 = ID, word 1 = timestamp) between two
// Avalon-MM read masters, after checking both words against expected values at boot.
module sysid_access_arbiter
    import sysid_arb_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID  = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS  = 32'h4F18_3B48,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_address,
    input  logic        m0_read,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,

    input  logic        m1_address,
    input  logic        m1_read,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,

    output logic        s_address,
    input  logic [31:0] s_readdata,

    output logic        boot_done,
    output logic        id_ok,
    output logic        id_mismatch
);

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_e      state_q;
    logic        grant_q;
    logic        last_grant_q;
    logic [2:0]  cnt_q;
    logic        s_addr_q;
    logic [31:0] id_word_q;
    logic [31:0] ts_word_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_rdv_q;
    logic        m1_rdv_q;
    logic        boot_done_q;
    logic        id_ok_q;
    logic        id_mismatch_q;

    logic        grant_valid;
    logic        grant_idx;

    sysid_rr_arbiter u_rr (
        .req         ({m1_read, m0_read}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT_ID;
            grant_q       <= MASTER_M0;
            last_grant_q  <= MASTER_M1;
            cnt_q         <= '0;
            s_addr_q      <= SYSID_WORD_ID;
            id_word_q     <= '0;
            ts_word_q     <= '0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
            m0_rdv_q      <= 1'b0;
            m1_rdv_q      <= 1'b0;
            boot_done_q   <= 1'b0;
            id_ok_q       <= 1'b0;
            id_mismatch_q <= 1'b0;
        end else begin
            unique case (state_q)
                BOOT_ID: begin
                    if (cnt_q == LAT) begin
                        id_word_q <= s_readdata;
                        cnt_q     <= '0;
                        s_addr_q  <= SYSID_WORD_TS;
                        state_q   <= BOOT_TS;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                BOOT_TS: begin
                    if (cnt_q == LAT) begin
                        ts_word_q <= s_readdata;
                        cnt_q     <= '0;
                        state_q   <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                CHECK: begin
                    boot_done_q   <= 1'b1;
                    id_ok_q       <= (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS);
                    id_mismatch_q <= !((id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS));
                    state_q       <= IDLE;
                end
                IDLE: begin
                    if (grant_valid) begin
                        grant_q  <= grant_idx;
                        s_addr_q <= (grant_idx == MASTER_M1) ? m1_address : m0_address;
                        cnt_q    <= '0;
                        state_q  <= SERVE;
                    end
                end
                SERVE: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == LAT) begin
                        last_grant_q <= grant_q;
                        if (grant_q == MASTER_M0) begin
                            m0_rdata_q <= s_readdata;
                            m0_rdv_q   <= 1'b1;
                        end else begin
                            m1_rdata_q <= s_readdata;
                            m1_rdv_q   <= 1'b1;
                        end
                    end else if (cnt_q == LAT + 3'd1) begin
                        m0_rdv_q <= 1'b0;
                        m1_rdv_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Acceptance is decoded from state so the grant cycle is visible without an extra register stage.
    assign m0_waitrequest   = !(state_q == SERVE && grant_q == MASTER_M0 && cnt_q == LAT);
    assign m1_waitrequest   = !(state_q == SERVE && grant_q == MASTER_M1 && cnt_q == LAT);
    assign m0_readdata      = m0_rdata_q;
    assign m1_readdata      = m1_rdata_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;
    assign s_address        = s_addr_q;
    assign boot_done        = boot_done_q;
    assign id_ok            = id_ok_q;
    assign id_mismatch      = id_mismatch_q;

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Scoreboard bench: instance A (defaults) and instance B (wrong expected TS, latency 2),
// each with its own sysid slave model; reads push expectations, a monitor pops them.
module tb_sysid_access_arbiter;

    typedef struct {
        int          m;
        logic [31:0] data;
        int          at;
    } exp_t;

    localparam logic [31:0] TS = 32'h4F18_3B48;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb [2][$];

    logic        m_read  [2][2];
    logic        m_addr  [2][2];
    logic        m_wait  [2][2];
    logic [31:0] m_rdata [2][2];
    logic        m_rdv   [2][2];
    logic        s_addr  [2];
    logic [31:0] s_data  [2];
    logic        boot_done [2];
    logic        id_ok     [2];
    logic        id_mm     [2];

    assign s_data[0] = s_addr[0] ? TS : 32'h0;
    assign s_data[1] = s_addr[1] ? TS : 32'h0;

    sysid_access_arbiter u_dut_a (
        .clock            (clock),
        .reset            (reset),
        .m0_address       (m_addr[0][0]),
        .m0_read          (m_read[0][0]),
        .m0_waitrequest   (m_wait[0][0]),
        .m0_readdata      (m_rdata[0][0]),
        .m0_readdatavalid (m_rdv[0][0]),
        .m1_address       (m_addr[0][1]),
        .m1_read          (m_read[0][1]),
        .m1_waitrequest   (m_wait[0][1]),
        .m1_readdata      (m_rdata[0][1]),
        .m1_readdatavalid (m_rdv[0][1]),
        .s_address        (s_addr[0]),
        .s_readdata       (s_data[0]),
        .boot_done        (boot_done[0]),
        .id_ok            (id_ok[0]),
        .id_mismatch      (id_mm[0])
    );

    sysid_access_arbiter #(
        .EXPECTED_TS  (32'h4F18_3B49),
        .READ_LATENCY (2)
    ) u_dut_b (
        .clock            (clock),
        .reset            (reset),
        .m0_address       (m_addr[1][0]),
        .m0_read          (m_read[1][0]),
        .m0_waitrequest   (m_wait[1][0]),
        .m0_readdata      (m_rdata[1][0]),
        .m0_readdatavalid (m_rdv[1][0]),
        .m1_address       (m_addr[1][1]),
        .m1_read          (m_read[1][1]),
        .m1_waitrequest   (m_wait[1][1]),
        .m1_readdata      (m_rdata[1][1]),
        .m1_readdatavalid (m_rdv[1][1]),
        .s_address        (s_addr[1]),
        .s_readdata       (s_data[1]),
        .boot_done        (boot_done[1]),
        .id_ok            (id_ok[1]),
        .id_mismatch      (id_mm[1])
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every readdatavalid pulse must match the oldest expectation of its instance.
    exp_t e;
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (m_rdv[d][0] || m_rdv[d][1]) begin
                check("rdv_exclusive", 32'(m_rdv[d][0]) + 32'(m_rdv[d][1]), 1);
            end
            for (int m = 0; m < 2; m++) begin
                if (m_rdv[d][m]) begin
                    if (sb[d].size() == 0) begin
                        check("rdv_expected", 32'(sb[d].size()), 1);
                    end else begin
                        e = sb[d].pop_front();
                        check("rdv_master", m, e.m);
                        check("rdv_data", m_rdata[d][m], e.data);
                        check("rdv_cycle", cyc, e.at);
                    end
                end
            end
        end
    end

    task automatic check_reset_state(int d);
        check("rst_m0_wait", m_wait[d][0], 1);
        check("rst_m1_wait", m_wait[d][1], 1);
        check("rst_m0_rdv", m_rdv[d][0], 0);
        check("rst_m1_rdv", m_rdv[d][1], 0);
        check("rst_m0_rdata", m_rdata[d][0], 0);
        check("rst_m1_rdata", m_rdata[d][1], 0);
        check("rst_s_address", s_addr[d], 0);
        check("rst_boot_done", boot_done[d], 0);
        check("rst_id_ok", id_ok[d], 0);
        check("rst_id_mismatch", id_mm[d], 0);
    endtask

    // Release reset and record on which edge each instance raises boot_done.
    task automatic release_and_boot();
        int r;
        int first [2];
        first = '{-1, -1};
        @(negedge clock);
        reset = 1'b0;
        r = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (boot_done[d] && first[d] < 0) first[d] = cyc - r;
            end
        end
        check("boot_edge_a", first[0], 3);
        check("boot_edge_b", first[1], 7);
        check("id_ok_a", id_ok[0], 1);
        check("id_mismatch_a", id_mm[0], 0);
        check("id_ok_b", id_ok[1], 0);
        check("id_mismatch_b", id_mm[1], 1);
    endtask

    // Called at a negedge with the instance in IDLE; the next edge samples the request.
    task automatic single_read(int d, int m, logic a, logic [31:0] exp_data, int rl);
        int t;
        int k;
        logic [31:0] other_data;
        other_data = m_rdata[d][1-m];
        t = cyc + 1;
        sb[d].push_back(exp_t'{m, exp_data, t + 1 + rl});
        m_addr[d][m] = a;
        m_read[d][m] = 1'b1;
        k = 0;
        while (m_wait[d][m] === 1'b1 && k < 16) begin
            @(negedge clock);
            k++;
        end
        check("accept_cycle", cyc, t + rl);
        check("other_wait_high", m_wait[d][1-m], 1);
        m_addr[d][m] = ~a;
        @(negedge clock);
        m_read[d][m] = 1'b0;
        @(negedge clock);
        check("other_rdata_held", m_rdata[d][1-m], other_data);
    endtask

    // Both masters of instance A request continuously; grants must alternate from m0.
    task automatic round_robin();
        int t;
        int n;
        int k;
        t = cyc + 1;
        sb[0].push_back(exp_t'{0, TS, t + 1});
        sb[0].push_back(exp_t'{1, 32'h0, t + 4});
        sb[0].push_back(exp_t'{0, TS, t + 7});
        sb[0].push_back(exp_t'{1, 32'h0, t + 10});
        m_addr[0][0] = 1'b1;
        m_addr[0][1] = 1'b0;
        m_read[0][0] = 1'b1;
        m_read[0][1] = 1'b1;
        n = 0;
        k = 0;
        while (n < 4 && k < 40) begin
            @(negedge clock);
            k++;
            if (!m_wait[0][0] || !m_wait[0][1]) begin
                check("rr_grant_idx", {31'd0, m_wait[0][0]}, 32'(n % 2));
                n++;
            end
        end
        check("rr_accepts", n, 4);
        @(negedge clock);
        m_read[0][0] = 1'b0;
        m_read[0][1] = 1'b0;
        @(negedge clock);
    endtask

    task automatic reset_mid_serve();
        m_addr[0][0] = 1'b1;
        m_read[0][0] = 1'b1;
        @(negedge clock);
        check("pre_reset_accept", m_wait[0][0], 0);
        #1 reset = 1'b1;
        #1;
        check_reset_state(0);
        check_reset_state(1);
        m_read[0][0] = 1'b0;
        repeat (2) @(negedge clock);
        release_and_boot();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) begin
                m_read[d][m] = 1'b0;
                m_addr[d][m] = 1'b0;
            end
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        release_and_boot();

        round_robin();
        single_read(0, 0, 1'b1, TS, 0);
        single_read(0, 1, 1'b0, 32'h0, 0);
        single_read(1, 0, 1'b1, TS, 2);
        single_read(1, 1, 1'b0, 32'h0, 2);

        reset_mid_serve();
        single_read(0, 0, 1'b1, TS, 0);

        repeat (4) @(negedge clock);
        check("sb_empty_a", 32'(sb[0].size()), 0);
        check("sb_empty_b", 32'(sb[1].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
